// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, branch encodings and the decoded control bundle shared by the decode stage.
package decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_VBNZ  = 6'b100010;
    localparam logic [5:0] OP_VBEZ  = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b100000;
    localparam logic [5:0] OP_LD    = 6'b100001;
    localparam logic [5:0] OP_NOP   = 6'b111100;
    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_VBNZ  = 2'b10;
    localparam logic [1:0] BR_VBEZ  = 2'b11;
    typedef struct packed {
        logic [4:0] ww;
        logic [5:0] op;
        logic [1:0] br;
        logic       store_en;
        logic       mem_en;
        logic       wr_en;
        logic       load;
        logic       illegal;
    } ctl_t;
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: per-register load busy counters with two busy lookup ports.
module load_scoreboard #(
    parameter int AW  = 5,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] rd_a,
    input  logic [AW-1:0] rd_b,
    output logic          busy_a,
    output logic          busy_b
);
    localparam int CW = $clog2(LAT + 1);
    logic [CW-1:0] cnt [2**AW];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 2**AW; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 2**AW; r++)
                cnt[r] <= (set_en && set_addr == AW'(r)) ? CW'(LAT) :
                          (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
        end
    end
    assign busy_a = cnt[rd_a] != '0;
    assign busy_b = cnt[rd_b] != '0;
endmodule

// File: rtl/pipelined_decode_unit.sv
// pipelined_decode_unit: registered valid/ready decode stage with load-use stall, flush and illegal flagging.
// DECODE_ILLEGAL_TRAP_EN makes an accepted illegal opcode a sticky trap that blocks input until reset.
module pipelined_decode_unit
    import decode_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16,
    parameter int LOAD_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_insn,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_ra,
    output logic [REG_ADDR_W-1:0] out_rb,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [4:0]            out_ww,
    output logic [5:0]            out_op,
    output logic [1:0]            out_br,
    output logic [IMM_W-1:0]      out_imm,
    output logic [IMM_W-1:0]      out_mem_addr,
    output logic                  out_store_en,
    output logic                  out_mem_en,
    output logic                  out_wr_en,
    output logic                  out_load,
    output logic                  out_illegal,
    output logic                  stall_hazard
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [REG_ADDR_W-1:0] rd;
        logic [IMM_W-1:0]      imm;
        logic [IMM_W-1:0]      mem_addr;
        ctl_t                  ctl;
    } bundle_t;
    bundle_t    d, q;
    logic [5:0] opc;
    logic       uses_a, uses_b, busy_a, busy_b, hazard, accept, trap;
    always_comb begin
        opc    = in_insn[31:26];
        d      = '0;
        uses_a = 1'b0;
        uses_b = 1'b0;
        case (opc)
            OP_RTYPE: begin
                d.ra        = REG_ADDR_W'(in_insn[20:16]);
                d.rb        = REG_ADDR_W'(in_insn[15:11]);
                d.rd        = REG_ADDR_W'(in_insn[25:21]);
                d.ctl.ww    = in_insn[10:6];
                d.ctl.op    = in_insn[5:0];
                d.ctl.wr_en = 1'b1;
                uses_a      = 1'b1;
                uses_b      = 1'b1;
            end
            OP_VBNZ, OP_VBEZ: begin
                d.ra     = REG_ADDR_W'(in_insn[25:21]);
                d.imm    = IMM_W'(in_insn[15:0]);
                d.ctl.br = opc[0] ? BR_VBEZ : BR_VBNZ;
                uses_a   = 1'b1;
            end
            OP_SW: begin
                d.ra           = REG_ADDR_W'(in_insn[25:21]);
                d.mem_addr     = IMM_W'(in_insn[15:0]);
                d.ctl.store_en = 1'b1;
                d.ctl.mem_en   = 1'b1;
                uses_a         = 1'b1;
            end
            OP_LD: begin
                d.rd         = REG_ADDR_W'(in_insn[25:21]);
                d.mem_addr   = IMM_W'(in_insn[15:0]);
                d.ctl.mem_en = 1'b1;
                d.ctl.load   = 1'b1;
                d.ctl.wr_en  = 1'b1;
            end
            OP_NOP: ;
            default: d.ctl.illegal = 1'b1;
        endcase
    end
    load_scoreboard #(.AW(REG_ADDR_W), .LAT(LOAD_LAT)) u_sb (
        .clk(clk), .reset(reset), .set_en(accept & d.ctl.load), .set_addr(d.rd),
        .rd_a(d.ra), .rd_b(d.rb), .busy_a(busy_a), .busy_b(busy_b)
    );
    assign hazard       = (uses_a & busy_a) | (uses_b & busy_b);
    assign stall_hazard = in_valid & hazard;
    assign in_ready     = ~reset & (~out_valid | out_ready) & ~hazard & ~flush & ~trap;
    assign accept       = in_valid & in_ready;
    // A bundle that leaves (consumed or flushed) is zeroed so no stale control survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (accept | flush | out_ready) begin
            out_valid <= accept;
            q         <= accept ? d : '0;
        end
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trap <= 1'b0;
        else if (accept & d.ctl.illegal) trap <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif
    assign out_ra       = q.ra;
    assign out_rb       = q.rb;
    assign out_rd       = q.rd;
    assign out_ww       = q.ctl.ww;
    assign out_op       = q.ctl.op;
    assign out_br       = q.ctl.br;
    assign out_imm      = q.imm;
    assign out_mem_addr = q.mem_addr;
    assign out_store_en = q.ctl.store_en;
    assign out_mem_en   = q.ctl.mem_en;
    assign out_wr_en    = q.ctl.wr_en;
    assign out_load     = q.ctl.load;
    assign out_illegal  = q.ctl.illegal | trap;
endmodule

// File: tb/tb_pipelined_decode_unit.sv
// tb_pipelined_decode_unit: table-driven decode vectors plus directed stall, hold, flush, illegal and reset sequences.
module tb_pipelined_decode_unit;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] in_insn = '0;
    logic        in_ready, out_valid, out_store_en, out_mem_en, out_wr_en, out_load, out_illegal, stall_hazard;
    logic [4:0]  out_ra, out_rb, out_rd, out_ww;
    logic [5:0]  out_op;
    logic [1:0]  out_br;
    logic [15:0] out_imm, out_mem_addr;
    int          tests = 0, fails = 0, n;

    pipelined_decode_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ra(out_ra), .out_rb(out_rb),
        .out_rd(out_rd), .out_ww(out_ww), .out_op(out_op), .out_br(out_br), .out_imm(out_imm),
        .out_mem_addr(out_mem_addr), .out_store_en(out_store_en), .out_mem_en(out_mem_en),
        .out_wr_en(out_wr_en), .out_load(out_load), .out_illegal(out_illegal), .stall_hazard(stall_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [79:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [79:0] mk(input logic [4:0] ra, rb, rd, ww, input logic [5:0] op,
                                       input logic [1:0] br, input logic [15:0] imm, mem,
                                       input logic st, me, wr, ld, il);
        return {15'd0, ra, rb, rd, ww, op, br, imm, mem, st, me, wr, ld, il};
    endfunction

    function automatic logic [79:0] got();
        return mk(out_ra, out_rb, out_rd, out_ww, out_op, out_br, out_imm, out_mem_addr,
                  out_store_en, out_mem_en, out_wr_en, out_load, out_illegal);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {79'd0, act}, {79'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] rt1;
        rt1 = mk(1, 2, 3, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs.push_back('{"rtype1", 32'hA8611101, rt1});
        vecs.push_back('{"rtype2", 32'hABE0FFFF, mk(0, 31, 31, 31, 63, 0, 0, 0, 0, 0, 1, 0, 0)});
        vecs.push_back('{"ld",     32'h84400040, mk(0, 0, 2, 0, 0, 0, 0, 16'h0040, 0, 1, 1, 1, 0)});
        vecs.push_back('{"vbnz",   32'h88E01234, mk(7, 0, 0, 0, 0, 2'b10, 16'h1234, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"vbez",   32'h8FE0FFFF, mk(31, 0, 0, 0, 0, 2'b11, 16'hFFFF, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"sw",     32'h80A0BEEF, mk(5, 0, 0, 0, 0, 0, 0, 16'hBEEF, 1, 1, 0, 0, 0)});
        vecs.push_back('{"nop",    32'hF3FFFFFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`ifndef DECODE_ILLEGAL_TRAP_EN
        vecs.push_back('{"ill0",   32'h00000000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
`endif
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_bundle", got(), 80'd0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_ready", in_ready, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            in_insn = vecs[i].insn; in_valid = 1'b1; out_ready = 1'b1;
            #1 chk1({vecs[i].name, "_rdy"}, in_ready, 1'b1);
            step();
            in_valid = 1'b0;
            chk1({vecs[i].name, "_vld"}, out_valid, 1'b1);
            chk(vecs[i].name, got(), vecs[i].exp);
            step(); step();
        end

        // load-use: R-type reading rb=2 behind LD r2
        in_insn = 32'h84400040; in_valid = 1'b1;
        step();
        chk1("lu_ld_vld", out_valid, 1'b1);
        chk("lu_ld_rd", 80'(out_rd), 80'd2);
        chk("lu_ld_addr", 80'(out_mem_addr), 80'h40);
        in_insn = 32'hA8611101;
        #1 n = 0;
        while (stall_hazard && n < 10) begin
            chk1("lu_stall_rdy", in_ready, 1'b0);
            n++;
            step();
        end
        chk("lu_stall_len", 80'(n), 80'd2);
        chk1("lu_post_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk1("lu_rt_vld", out_valid, 1'b1);
        chk("lu_rt", got(), rt1);
        step();

        // backpressure hold
        in_insn = 32'hABE0FFFF; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_insn = 32'hA8611101;
        for (int k = 0; k < 3; k++) begin
            chk1("hold_vld", out_valid, 1'b1);
            chk("hold_fields", got(), mk(0, 31, 31, 31, 63, 0, 0, 0, 0, 0, 1, 0, 0));
            chk1("hold_rdy", in_ready, 1'b0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        for (int k = 0; k < 3; k++) begin
            n += int'(out_valid & out_ready);
            step();
        end
        chk("hold_consumed_once", 80'(n), 80'd1);

        // flush a held SW while LD r4 is counting down
        in_insn = 32'h84800010; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_insn = 32'h80A0BEEF;
        step();
        chk1("fl_sw_held", out_store_en, 1'b1);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        #1 chk1("fl_rdy", in_ready, 1'b0);
        step();
        flush = 1'b0;
        chk1("fl_vld", out_valid, 1'b0);
        chk1("fl_store", out_store_en, 1'b0);
        in_insn = 32'hA8240000; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk1("fl_cnt_runs", stall_hazard, 1'b0);
        chk1("fl_next_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("fl_next", got(), mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step();

        // illegal opcode 0x3F
        in_insn = 32'hFC123456; in_valid = 1'b1;
        step();
        chk1("ill_vld", out_valid, 1'b1);
        chk("ill_bundle", got(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        in_insn = 32'hA8611101;
`ifdef DECODE_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            chk1("trap_rdy", in_ready, 1'b0);
            chk1("trap_ill", out_illegal, 1'b1);
            step();
        end
        reset = 1'b1;
        #1 chk1("trap_cleared", out_illegal, 1'b0);
        step();
        reset = 1'b0; in_valid = 1'b0;
        step();
`else
        #1 chk1("ill_next_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("ill_next", got(), rt1);
        step();
`endif

        // reset in the middle of a load-use stall
        in_insn = 32'h84400040; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_insn = 32'hA8611101;
        #1 chk1("rs_pre_stall", stall_hazard, 1'b1);
        #2 reset = 1'b1;
        #1 chk("rs_bundle", got(), 80'd0);
        chk1("rs_vld", out_valid, 1'b0);
        chk1("rs_stall", stall_hazard, 1'b0);
        chk1("rs_rdy", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk1("rs_post_stall", stall_hazard, 1'b0);
        chk1("rs_post_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk1("rs_rt_vld", out_valid, 1'b1);
        chk("rs_rt", got(), rt1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_decode_unit.md
Name: pipelined_decode_unit

Overview:
Registered, handshaked decode stage for the vector core. It sits between instruction fetch and register-file read, and produces one decoded bundle per accepted instruction. Compared with the purely combinational decoder it adds:
- valid/ready flow control,
- a per-register load-use scoreboard that stalls issue,
- branch flush,
- explicit flagging of illegal opcodes.

Parameters:
- REG_ADDR_W, 5, register address width (register file depth is 2**REG_ADDR_W).
- IMM_W, 16, branch immediate and memory address width.
- LOAD_LAT, 2, cycles a load destination stays busy after issue (range 1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_insn  in  32  instruction word.
- flush  in  1  branch resolved taken; kill the held bundle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_ra, out_rb, out_rd  out  REG_ADDR_W  source A, source B, destination.
- out_ww  out  5  write-width field.
- out_op  out  6  ALU operation.
- out_br  out  2  00 none, 10 VBNZ, 11 VBEZ.
- out_imm  out  IMM_W  branch immediate.
- out_mem_addr  out  IMM_W  memory address.
- out_store_en, out_mem_en, out_wr_en, out_load, out_illegal  out  1 each  control flags.
- stall_hazard  out  1  load-use stall asserted this cycle.

Behaviour:

Reset:
- All outputs are 0, the scoreboard is cleared, in_ready is 0 during reset.

Opcodes (insn[31:26]):
- 101010 R-type: ra=[20:16], rb=[15:11], rd=[25:21], ww=[10:6], op=[5:0], wr_en=1.
- 100010 VBNZ: ra=[25:21], imm=[15:0], br=10.
- 100011 VBEZ: ra=[25:21], imm=[15:0], br=11.
- 100000 SW: ra=[25:21] (store data), mem_addr=[15:0], store_en=1, mem_en=1.
- 100001 LD: rd=[25:21], mem_addr=[15:0], mem_en=1, load=1, wr_en=1.
- 111100 NOP: every field is 0.
- Any other opcode: NOP fields with out_illegal=1.
- Every field not listed for an opcode is 0.

Source usage:
- uses_a is set for R-type, VBNZ, VBEZ and SW.
- uses_b is set for R-type only.

Hazard:
- hazard = (uses_a & busy[ra]) | (uses_b & busy[rb]), evaluated on in_insn.
- stall_hazard = in_valid & hazard.

Handshake:
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- An input is accepted when in_valid & in_ready; fields register on that edge, giving 1-cycle latency.
- out_valid holds with stable fields until out_ready.
- If out_ready is high and nothing is accepted, out_valid drops to 0.

Scoreboard:
- One down-counter per register, width ceil(log2(LOAD_LAT+1)).
- Accepting an LD sets cnt[rd] = LOAD_LAT. Every other nonzero counter decrements each cycle.
- busy[r] = (cnt[r] != 0).
- A new LD to a register whose counter is still nonzero reloads it to LOAD_LAT.

Flush:
- Takes priority over acceptance: out_valid is 0 next cycle and the input is not taken.
- Scoreboard counters keep counting; loads already issued are not cancelled.

Reset mid-operation:
- Clears everything asynchronously; no partial bundle survives.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: an accepted illegal opcode sets a sticky internal trap bit. While trap is set, in_ready is forced to 0 and out_illegal stays 1 until reset.
- Undefined: an illegal opcode passes through as a NOP bundle with out_illegal=1 for that bundle only; the stream continues.

Decomposition:
- Package decode_pkg: opcode localparams (OP_RTYPE, OP_VBNZ, OP_VBEZ, OP_SW, OP_LD, OP_NOP), BR encodings, and a packed decoded-bundle typedef.
- Sub-module load_scoreboard: per-register counters, set on load issue, busy lookup for two read ports.
- The combinational field extraction stays inline in pipelined_decode_unit.

Test Plan:
1. R-type 0xA8611101 with out_ready=1 -> next cycle out_valid=1, rd=3, ra=1, rb=2, ww=4, op=1, wr_en=1.
2. LD 0x84400040, then R-type reading rb=2, LOAD_LAT=2 -> LD issues, rd=2, mem_addr=0x0040; stall_hazard=1 and in_ready=0 for exactly 2 cycles; then the R-type issues.
3. Hold out_ready=0 for 3 cycles with an R-type bundle held -> fields stable, in_ready=0; on release the bundle is consumed once.
4. flush=1 while an SW bundle is held -> out_valid=0 next cycle, no store issued, a pending LD counter continues decrementing.
5. Opcode 0x3F -> out_illegal=1 with NOP fields. With DECODE_ILLEGAL_TRAP_EN, in_ready stays 0 until reset; without it, the next instruction issues normally.
6. Assert reset mid-stall -> all outputs 0 immediately; after release, the previously stalled R-type issues without stalling.
